axon_spike_dispatcher: RTL
==========================

# axon_spike_dispatcher

Buffers incoming axon spike events for the next tick in a double-buffered bitmap. On each tick it walks the current-tick bitmap in ascending axon order. For every set bit it presents the axon index to the downstream `synapse_connection` stage, holds it there, and waits for `synap_con_done`. It sits directly upstream of `synapse_connection` and downstream of the core's spike router/input port.

## Interface
Parameters:
- `NUM_AXONS`, default 256: number of axons; must be a power of two ≥ 2. `AW = $clog2(NUM_AXONS)`.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `tick`, in, 1: one-cycle pulse that starts processing of buffered spikes.
- `spike_valid`, in, 1: spike event strobe; always accepted, no back-pressure.
- `spike_axon`, in, AW: target axon index of the spike event.
- `axon_number`, out, AW: axon index presented to `synapse_connection`.
- `syn_enable`, out, 1: enable for `synapse_connection`.
- `synap_con_done`, in, 1: one-cycle pulse from `synapse_connection` when its neuron scan completes.
- `busy`, out, 1: high whenever the FSM is not in IDLE.
- `tick_done`, out, 1: one-cycle pulse when all spikes of the tick have been dispatched.
- `tick_overrun`, out, 1: one-cycle pulse when a `tick` arrives while `busy`.

## Operation
- There are two NUM_AXONS-bit bitmaps, `cur` and `nxt`.
- Spike writes:
  - `spike_valid` sets `nxt[spike_axon]`.
  - Duplicate writes to the same axon are idempotent.
- FSM states: IDLE, SCAN, ISSUE, GAP, DONE.
- IDLE:
  - On `tick`, swap the bitmaps (`cur<=nxt`, `nxt<=cur`), set `ptr<=0`, and go to SCAN.
  - The old `cur` is guaranteed all-zero at this point, so the new `nxt` starts empty.
- SCAN examines one bit per cycle:
  - `cur[ptr]=1`: `axon_number<=ptr`, enable register set, go to ISSUE.
  - `cur[ptr]=0` and `ptr<NUM_AXONS-1`: `ptr<=ptr+1`.
  - `cur[ptr]=0` and `ptr==NUM_AXONS-1`: go to DONE.
- ISSUE:
  - `axon_number` and the enable register are held stable.
  - `syn_enable = en_q & ~synap_con_done`, so enable is low in the cycle `synap_con_done` is high. This lets the downstream counter re-arm.
  - On `synap_con_done`: clear `en_q`, clear `cur[ptr]`, go to GAP.
- GAP:
  - Exactly one cycle with `syn_enable=0`.
  - If `ptr==NUM_AXONS-1`, go to DONE; otherwise `ptr<=ptr+1` and go to SCAN.
- DONE: `tick_done=1` for one cycle, then go to IDLE.
- Tick while busy:
  - The tick is ignored: no swap, and the in-progress scan continues.
  - `tick_overrun` pulses in the next cycle.
- Spike write in the same cycle as an accepted tick: the bit lands in the post-swap `nxt`, i.e. it belongs to the following tick.
- Spike write in the same cycle as an ignored tick: the bit lands in the current `nxt`.
- `synap_con_done` outside ISSUE is ignored.
- `ptr` never wraps within a tick; the index range is 0..NUM_AXONS-1 with no overflow.

## Timing
- Reset values:
  - Outputs: `axon_number=0`, `syn_enable=0`, `busy=0`, `tick_done=0`, `tick_overrun=0`.
  - Internal: both bitmaps all-zero, `ptr=0`, state IDLE.
- Reset mid-operation: at the next edge all state is as above. Any half-dispatched axon is dropped, and buffered spikes are lost.
- All outputs are registered except `syn_enable`, which is `en_q` gated by `synap_con_done`.
- `busy` rises the cycle after an accepted `tick`.
- SCAN costs 1 cycle per examined axon. Each dispatched axon costs 1 SCAN + (ISSUE until done) + 1 GAP cycle.
- Empty tick: `tick` at cycle 0; SCAN cycles 1..NUM_AXONS; `tick_done` at cycle NUM_AXONS+1; `busy=0` from NUM_AXONS+2.
- `axon_number` is valid the same cycle `syn_enable` first rises. It is unchanged until after `synap_con_done`.

## Test plan
- Reset, then `tick` with no spikes -> `syn_enable` never rises; `tick_done` pulses at cycle 257 (NUM_AXONS=256); `busy` high for cycles 1..257.
- Spikes to axons 5, 200, 5 (duplicate), then `tick`; model `synap_con_done` 10 cycles after each enable rise -> exactly two dispatches, `axon_number=5` then `200`; `syn_enable` is 0 in each done cycle and the following GAP cycle; then `tick_done`.
- Spike to axon 255 only -> single dispatch with `axon_number=255`; DONE follows GAP without further SCAN cycles.
- Second `tick` during a dispatch -> `tick_overrun` pulses once; the scan completes unaffected. Spikes written during the scan are dispatched only on the next accepted tick.
- `spike_valid` to axon 7 in the same cycle as an accepted `tick` -> axon 7 is not dispatched this tick; it is dispatched on the next tick.
- Assert `rst` while in ISSUE -> the next cycle shows all outputs at reset values. A subsequent `tick` behaves as an empty tick.

Source files
------------

// File: rtl/axon_spike_dispatcher_if.sv
// Handshake bundle between the spike router, the axon dispatcher and the
// downstream synapse_connection stage.
interface axon_spike_dispatcher_if #(
    parameter int AW = 8
);
    logic          tick;
    logic          spike_valid;
    logic [AW-1:0] spike_axon;
    logic [AW-1:0] axon_number;
    logic          syn_enable;
    logic          synap_con_done;
    logic          busy;
    logic          tick_done;
    logic          tick_overrun;

    modport master (
        output tick,
        output spike_valid,
        output spike_axon,
        output synap_con_done,
        input  axon_number,
        input  syn_enable,
        input  busy,
        input  tick_done,
        input  tick_overrun
    );

    modport slave (
        input  tick,
        input  spike_valid,
        input  spike_axon,
        input  synap_con_done,
        output axon_number,
        output syn_enable,
        output busy,
        output tick_done,
        output tick_overrun
    );
endinterface

// File: rtl/axon_spike_dispatcher.sv
// Double-buffered axon spike bitmap; on each tick walks the current bitmap in
// ascending order and hands every set axon to synapse_connection in turn.
//
// state | meaning
// IDLE  | waiting for tick; spikes accumulate in nxt
// SCAN  | examining cur[ptr], one axon per cycle
// ISSUE | axon_number/enable held until synap_con_done
// GAP   | one enable-low cycle so the downstream counter re-arms
// DONE  | tick_done pulse, back to IDLE
module axon_spike_dispatcher #(
    parameter int NUM_AXONS = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    axon_spike_dispatcher_if.slave  bus
);
    localparam int AW = $clog2(NUM_AXONS);
    localparam logic [AW-1:0] PTR_LAST = AW'(NUM_AXONS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_ISSUE,
        S_GAP,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [AW-1:0]        ptr_q, ptr_d;
    logic [AW-1:0]        axon_q, axon_d;
    logic                 en_q, en_d;
    logic [NUM_AXONS-1:0] cur_q, nxt_q;
    logic [NUM_AXONS-1:0] spike_mask;
    logic                 swap;
    logic                 clr_cur;
    logic                 busy_q;
    logic                 tick_done_q;
    logic                 tick_overrun_q;

    always_comb begin
        spike_mask = '0;
        if (bus.spike_valid) begin
            spike_mask[bus.spike_axon] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            axon_q  <= '0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            axon_q  <= axon_d;
            en_q    <= en_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        axon_d  = axon_q;
        en_d    = en_q;
        swap    = 1'b0;
        clr_cur = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.tick) begin
                    swap    = 1'b1;
                    ptr_d   = '0;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (cur_q[ptr_q]) begin
                    axon_d  = ptr_q;
                    en_d    = 1'b1;
                    state_d = S_ISSUE;
                end else if (ptr_q == PTR_LAST) begin
                    state_d = S_DONE;
                end else begin
                    ptr_d = ptr_q + AW'(1);
                end
            end
            S_ISSUE: begin
                if (bus.synap_con_done) begin
                    en_d    = 1'b0;
                    clr_cur = 1'b1;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (ptr_q == PTR_LAST) begin
                    state_d = S_DONE;
                end else begin
                    ptr_d   = ptr_q + AW'(1);
                    state_d = S_SCAN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Old cur is empty at swap time, so OR-ing the spike in gives a clean nxt.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_q <= '0;
            nxt_q <= '0;
        end else if (swap) begin
            cur_q <= nxt_q;
            nxt_q <= cur_q | spike_mask;
        end else begin
            nxt_q <= nxt_q | spike_mask;
            if (clr_cur) begin
                cur_q[ptr_q] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q         <= 1'b0;
            tick_done_q    <= 1'b0;
            tick_overrun_q <= 1'b0;
        end else begin
            busy_q         <= (state_d != S_IDLE);
            tick_done_q    <= (state_d == S_DONE);
            tick_overrun_q <= bus.tick & (state_q != S_IDLE);
        end
    end

    assign bus.axon_number  = axon_q;
    assign bus.syn_enable   = en_q & ~bus.synap_con_done;
    assign bus.busy         = busy_q;
    assign bus.tick_done    = tick_done_q;
    assign bus.tick_overrun = tick_overrun_q;
endmodule
